// File: rtl/line_fill_mem_pkg.sv
// Shared widths, counter type, FSM state encoding and line packing helper.
// No logic or latency of its own; types only.
// No flow control; consumed by line_fill_mem and line_fill_mem_array.
package line_fill_mem_pkg;

   localparam int WORD_WIDTH     = 32;
   localparam int LINE_WIDTH     = 128;
   localparam int WORDS_PER_LINE = 4;
   localparam int CNT_WIDTH      = 4;

   typedef logic [WORD_WIDTH-1:0] word_t;
   typedef logic [LINE_WIDTH-1:0] line_t;
   typedef logic [CNT_WIDTH-1:0]  cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RD_WAIT = 2'b01,
      ST_RD_RESP = 2'b10,
      ST_WR_WAIT = 2'b11
   } state_t;

   // Word offset 0 lands in the most significant slot of the line.
   function automatic line_t pack_line(input word_t w0, input word_t w1,
                                       input word_t w2, input word_t w3);
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/line_fill_mem_array.sv
// Backing store: one synchronous word write port, one combinational line read port.
// Write lands on the next clock edge; line read is combinational from rline.
// No backpressure; the controller owns all sequencing. Not reset.
module line_fill_mem_array
   import line_fill_mem_pkg::*;
#(
   parameter int MEMWORDS = 4096,
   parameter int AW       = $clog2(MEMWORDS)
)(
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  word_t         wdata,
   input  logic [AW-3:0] rline,
   output line_t         rdata
);

   word_t mem [MEMWORDS];

   // Word write; the store deliberately has no reset so contents survive it.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = pack_line(mem[{rline, 2'd0}], mem[{rline, 2'd1}],
                            mem[{rline, 2'd2}], mem[{rline, 2'd3}]);

endmodule

// File: rtl/line_fill_mem.sv
// Line-fill memory model: 128-bit line reads and 32-bit write-through for a cache.
// Latency: line_valid / wr_done pulse LATENCY+1 cycles after the accepting edge.
// Backpressure: busy high outside IDLE; requests seen while busy are dropped, not queued.
// Optional macro LINE_FILL_ADDR_CHECK_EN adds addr_err and range checking.
module line_fill_mem
   import line_fill_mem_pkg::*;
#(
   parameter int MEMWORDS = 4096,
   parameter int LATENCY  = 4
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rd_req,
   input  logic                  wr_req,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   output logic                  busy,
   output logic                  line_valid,
   output logic [LINE_WIDTH-1:0] line_out,
   output logic                  wr_done
`ifdef LINE_FILL_ADDR_CHECK_EN
   ,
   output logic                  addr_err
`endif
);

   localparam int   AW       = $clog2(MEMWORDS);
   localparam cnt_t CNT_LOAD = cnt_t'(LATENCY - 1);

   state_t      state;
   cnt_t        cnt;
   logic [29:0] addr_q;      // word address addr[31:2] of the accepted request
   word_t       wdata_q;
   logic        wr_last;     // countdown finished; commit write on the next edge
   logic        out_of_range;
   logic        mem_we;
   line_t       mem_line;
   logic        unused_bits;

`ifdef LINE_FILL_ADDR_CHECK_EN
   assign out_of_range = ({2'b00, addr_q} >= 32'(MEMWORDS));
`else
   // Without range checking, upper word-address bits simply alias (wrap).
   assign out_of_range = 1'b0;
`endif

   // Write strobe is decoded from registered state so an async reset kills it at once.
   assign mem_we = (state == ST_WR_WAIT) && wr_last && !out_of_range;

   // Byte offset is ignored and upper bits alias when the store is small.
   assign unused_bits = ^{addr[1:0], addr_q};

   line_fill_mem_array #(
      .MEMWORDS (MEMWORDS)
   ) u_array (
      .clock (clock),
      .we    (mem_we),
      .waddr (addr_q[AW-1:0]),
      .wdata (wdata_q),
      .rline (addr_q[AW-1:2]),
      .rdata (mem_line)
   );

   // Control FSM with registered busy/pulse/line outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_last    <= 1'b0;
         busy       <= 1'b0;
         line_valid <= 1'b0;
         line_out   <= '0;
         wr_done    <= 1'b0;
`ifdef LINE_FILL_ADDR_CHECK_EN
         addr_err   <= 1'b0;
`endif
      end else begin
         line_valid <= 1'b0;
         wr_done    <= 1'b0;
`ifdef LINE_FILL_ADDR_CHECK_EN
         addr_err   <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               // Read wins over a simultaneous write; the write is dropped.
               if (rd_req) begin
                  addr_q <= addr[31:2];
                  cnt    <= CNT_LOAD;
                  busy   <= 1'b1;
                  state  <= ST_RD_WAIT;
               end else if (wr_req) begin
                  addr_q  <= addr[31:2];
                  wdata_q <= wdata;
                  cnt     <= CNT_LOAD;
                  wr_last <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ST_WR_WAIT;
               end
            end

            ST_RD_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_RD_RESP;
               end else begin
                  cnt <= cnt - cnt_t'(1);
               end
            end

            ST_RD_RESP: begin
               line_out   <= out_of_range ? '0 : mem_line;
               line_valid <= 1'b1;
`ifdef LINE_FILL_ADDR_CHECK_EN
               addr_err   <= out_of_range;
`endif
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end

            ST_WR_WAIT: begin
               // One extra step after the countdown so writes complete on the
               // same LATENCY+1 schedule as line responses.
               if (wr_last) begin
                  wr_done  <= 1'b1;
`ifdef LINE_FILL_ADDR_CHECK_EN
                  addr_err <= out_of_range;
`endif
                  wr_last  <= 1'b0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else if (cnt == '0) begin
                  wr_last <= 1'b1;
               end else begin
                  cnt <= cnt - cnt_t'(1);
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
